branch_controller: RTL and testbench

Sequences branch resolution results from the two issue pipes into a single fetch redirect. It compares each resolved branch against the front-end prediction, holds a misprediction until its delay-slot instruction has issued, then emits a one-cycle redirect and flush pulse. The block sits between the two `branch_resolver` instances in the execute stage and the fetch/issue control. It also keeps wrapping branch and misprediction counters for performance monitoring.

---
 rtl/branch_controller.sv | 123 ++++++++++++
 tb/tb_branch_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_controller.sv
// Branch resolution sequencer: picks the oldest resolved branch from the two issue pipes,
// holds a misprediction until its delay slot has issued, then pulses redirect/flush to fetch.
package branch_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } branch_resolved_t;
endpackage

// state       | meaning
// ST_IDLE     | no mispredict pending; accepting resolved branches
// ST_WAIT_DS  | mispredict latched, waiting for its delay slot to issue
// ST_REDIRECT | one-cycle redirect/flush pulse to fetch
module branch_controller
  import branch_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  branch_resolved_t     resolved0,
  input  branch_resolved_t     resolved1,
  input  logic [31:0]          pc0,
  input  logic [31:0]          pc1,
  input  logic                 pred0_taken,
  input  logic                 pred1_taken,
  input  logic [31:0]          pred0_target,
  input  logic [31:0]          pred1_target,
  input  logic                 pipe1_valid,
  input  logic                 ds_valid,
  input  logic                 stall,
  input  logic                 except_flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush_younger,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_DS  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pend_pc;

  logic        sel_valid, sel_taken, sel_pipe0, sel_pred_taken;
  logic [31:0] sel_target, sel_pc, sel_pred_target;
  logic [31:0] correct_pc;
  logic        mispredict, accept;

  // Pipe 0 wins; when it resolves, pipe 1 holds its delay slot, not a branch.
  always_comb begin
    sel_pipe0       = resolved0.valid;
    sel_valid       = resolved0.valid | resolved1.valid;
    sel_taken       = resolved1.taken;
    sel_target      = resolved1.target;
    sel_pc          = pc1;
    sel_pred_taken  = pred1_taken;
    sel_pred_target = pred1_target;
    if (resolved0.valid) begin
      sel_taken       = resolved0.taken;
      sel_target      = resolved0.target;
      sel_pc          = pc0;
      sel_pred_taken  = pred0_taken;
      sel_pred_target = pred0_target;
    end
  end

  assign correct_pc = sel_taken ? sel_target : sel_pc + 32'd8;
  assign mispredict = (sel_pred_taken != sel_taken) |
                      (sel_taken & (sel_pred_target != sel_target));
  assign accept     = (state == ST_IDLE) & ~stall & ~except_flush & sel_valid;

  always_comb begin
    state_nxt = state;
    if (except_flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept & mispredict)
            state_nxt = (sel_pipe0 & pipe1_valid) ? ST_REDIRECT : ST_WAIT_DS;
        end
        ST_WAIT_DS: begin
          if (ds_valid & ~stall)
            state_nxt = ST_REDIRECT;
        end
        ST_REDIRECT: state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      flush_younger  <= 1'b0;
      busy           <= 1'b0;
      pend_pc        <= '0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= (state_nxt == ST_REDIRECT);
      flush_younger  <= (state_nxt == ST_REDIRECT);
      busy           <= (state_nxt != ST_IDLE);
      if (accept) begin
        branch_cnt <= branch_cnt + 1'b1;
        if (mispredict) begin
          mispred_cnt <= mispred_cnt + 1'b1;
          pend_pc     <= correct_pc;
        end
      end
    end
  end

  assign redirect_pc = pend_pc;

endmodule

// File: tb/tb_branch_controller.sv
// Self-checking bench for branch_controller: directed cases plus randomized traffic,
// compared every cycle against a behavioural model; a CNT_WIDTH=4 copy exercises wrap.
module tb_branch_controller;
  import branch_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  branch_resolved_t r0, r1;
  logic [31:0]      pc0, pc1, pt0, pt1;
  logic             pk0, pk1, pipe1_valid, ds_valid, stall, except_flush;

  logic        rv, fy, bz;
  logic [31:0] rpc, bcnt, mcnt;
  logic        rv4, fy4, bz4;
  logic [31:0] rpc4;
  logic [3:0]  bcnt4, mcnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_pend, m_redir;
  logic [31:0] m_pc, m_bcnt, m_mcnt;

  always #5 clk = ~clk;

  branch_controller dut (
    .clk(clk), .rst(rst), .resolved0(r0), .resolved1(r1), .pc0(pc0), .pc1(pc1),
    .pred0_taken(pk0), .pred1_taken(pk1), .pred0_target(pt0), .pred1_target(pt1),
    .pipe1_valid(pipe1_valid), .ds_valid(ds_valid), .stall(stall),
    .except_flush(except_flush), .redirect_valid(rv), .redirect_pc(rpc),
    .flush_younger(fy), .busy(bz), .branch_cnt(bcnt), .mispred_cnt(mcnt)
  );

  branch_controller #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .resolved0(r0), .resolved1(r1), .pc0(pc0), .pc1(pc1),
    .pred0_taken(pk0), .pred1_taken(pk1), .pred0_target(pt0), .pred1_target(pt1),
    .pipe1_valid(pipe1_valid), .ds_valid(ds_valid), .stall(stall),
    .except_flush(except_flush), .redirect_valid(rv4), .redirect_pc(rpc4),
    .flush_younger(fy4), .busy(bz4), .branch_cnt(bcnt4), .mispred_cnt(mcnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: consumes the inputs present at a rising edge.
  task automatic model_step();
    bit          use0, v, tk, ptk, mis;
    logic [31:0] tgt, pc, ptg;
    if (rst) begin
      m_pend = 0; m_redir = 0; m_pc = 0; m_bcnt = 0; m_mcnt = 0;
      return;
    end
    if (except_flush) begin
      m_pend = 0; m_redir = 0;
    end else if (m_redir) begin
      m_redir = 0;
    end else if (m_pend) begin
      if (ds_valid && !stall) begin m_pend = 0; m_redir = 1; end
    end else if (!stall) begin
      use0 = r0.valid;
      v    = r0.valid || r1.valid;
      tk   = use0 ? r0.taken  : r1.taken;
      tgt  = use0 ? r0.target : r1.target;
      pc   = use0 ? pc0 : pc1;
      ptk  = use0 ? pk0 : pk1;
      ptg  = use0 ? pt0 : pt1;
      if (v) begin
        m_bcnt = m_bcnt + 1;
        mis = (ptk != tk) || (tk && ptg != tgt);
        if (mis) begin
          m_mcnt = m_mcnt + 1;
          m_pc   = tk ? tgt : pc + 32'd8;
          if (use0 && pipe1_valid) m_redir = 1; else m_pend = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("redirect_valid", {31'd0, rv}, {31'd0, m_redir});
    chk("flush_younger",  {31'd0, fy}, {31'd0, m_redir});
    chk("busy",           {31'd0, bz}, {31'd0, m_pend | m_redir});
    chk("redirect_pc",    rpc, m_pc);
    chk("branch_cnt",     bcnt, m_bcnt);
    chk("mispred_cnt",    mcnt, m_mcnt);
    chk("branch_cnt4",    {28'd0, bcnt4}, {28'd0, m_bcnt[3:0]});
    chk("mispred_cnt4",   {28'd0, mcnt4}, {28'd0, m_mcnt[3:0]});
    chk("redirect_valid4", {31'd0, rv4}, {31'd0, m_redir});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; r0 = '0; r1 = '0; pc0 = 0; pc1 = 0; pt0 = 0; pt1 = 0;
    pk0 = 0; pk1 = 0; pipe1_valid = 0; ds_valid = 0; stall = 0; except_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle(); cycle();
    rst = 0;
  endtask

  // pipe-0 mispredict (taken, predicted not-taken) with delay slot in pipe 1
  task automatic p0_mispredict(input logic [31:0] pc, input logic [31:0] tgt);
    idle_inputs();
    r0 = '{valid: 1'b1, taken: 1'b1, target: tgt};
    pc0 = pc; pipe1_valid = 1;
  endtask

  initial begin
    do_reset();
    chk("reset_redirect_valid", {31'd0, rv}, 32'd0);
    chk("reset_busy",           {31'd0, bz}, 32'd0);
    chk("reset_redirect_pc",    rpc, 32'd0);
    chk("reset_branch_cnt",     bcnt, 32'd0);

    // pipe-0 taken, predicted not-taken, delay slot in same bundle
    p0_mispredict(32'h8000_0000, 32'h8000_0100);
    cycle();
    chk("t1_redirect_valid", {31'd0, rv}, 32'd1);
    chk("t1_flush_younger",  {31'd0, fy}, 32'd1);
    chk("t1_redirect_pc",    rpc, 32'h8000_0100);
    chk("t1_mispred_cnt",    mcnt, 32'd1);
    chk("t1_branch_cnt",     bcnt, 32'd1);
    idle_inputs();
    cycle();
    chk("t1_pulse_end", {31'd0, rv}, 32'd0);

    // pipe-1 not-taken, predicted taken; delay slot arrives later, first attempt stalled
    r1 = '{valid: 1'b1, taken: 1'b0, target: 32'h9000_0000};
    pc1 = 32'h8000_0044; pk1 = 1; pt1 = 32'h9000_0000;
    cycle();
    chk("t2_busy_a", {31'd0, bz}, 32'd1);
    idle_inputs();
    cycle();
    chk("t2_busy_b", {31'd0, bz}, 32'd1);
    ds_valid = 1; stall = 1;
    cycle();
    chk("t2_busy_c", {31'd0, bz}, 32'd1);
    chk("t2_no_redirect", {31'd0, rv}, 32'd0);
    stall = 0;
    cycle();
    chk("t2_redirect_valid", {31'd0, rv}, 32'd1);
    chk("t2_redirect_pc", rpc, 32'h8000_004C);
    chk("t2_busy_d", {31'd0, bz}, 32'd1);
    idle_inputs();
    cycle();

    // correct prediction, then target mismatch
    r0 = '{valid: 1'b1, taken: 1'b1, target: 32'h200};
    pk0 = 1; pt0 = 32'h200;
    cycle();
    chk("t3_no_redirect", {31'd0, rv}, 32'd0);
    chk("t3_busy", {31'd0, bz}, 32'd0);
    chk("t3_branch_cnt", bcnt, 32'd3);
    chk("t3_mispred_cnt", mcnt, 32'd2);
    r0 = '{valid: 1'b1, taken: 1'b1, target: 32'h100};
    pk0 = 1; pt0 = 32'h104; pipe1_valid = 1;
    cycle();
    chk("t3b_redirect_pc", rpc, 32'h100);
    chk("t3b_mispred_cnt", mcnt, 32'd3);
    idle_inputs();
    cycle();

    // both pipes valid: pipe 0 correct, pipe 1 wrong -> pipe 1 ignored
    r0 = '{valid: 1'b1, taken: 1'b0, target: 32'h0};
    r1 = '{valid: 1'b1, taken: 1'b1, target: 32'h300};
    pk0 = 0; pk1 = 0; pipe1_valid = 1;
    cycle();
    chk("t4_no_redirect", {31'd0, rv}, 32'd0);
    chk("t4_branch_cnt", bcnt, 32'd5);
    chk("t4_mispred_cnt", mcnt, 32'd3);
    idle_inputs();

    // exception flush during WAIT_DS drops the redirect
    r1 = '{valid: 1'b1, taken: 1'b1, target: 32'h400};
    pc1 = 32'h50;
    cycle();
    idle_inputs();
    except_flush = 1;
    cycle();
    chk("t5_busy_after_flush", {31'd0, bz}, 32'd0);
    except_flush = 0; ds_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_no_redirect", {31'd0, rv}, 32'd0);
    end
    idle_inputs();

    // reset during REDIRECT
    p0_mispredict(32'h1000, 32'h2000);
    cycle();
    chk("t6_in_redirect", {31'd0, rv}, 32'd1);
    idle_inputs();
    rst = 1;
    cycle();
    chk("t6_rst_rv", {31'd0, rv}, 32'd0);
    chk("t6_rst_fy", {31'd0, fy}, 32'd0);
    chk("t6_rst_busy", {31'd0, bz}, 32'd0);
    chk("t6_rst_pc", rpc, 32'd0);
    chk("t6_rst_cnt", mcnt, 32'd0);
    rst = 0;

    // 16 mispredicts wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      p0_mispredict(32'h10 * i, 32'h4000 + 32'h10 * i);
      cycle();
      idle_inputs();
      cycle();
    end
    chk("t7_wrap_mispred4", {28'd0, mcnt4}, 32'd0);
    chk("t7_mispred32", mcnt, 32'd16);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      except_flush = ($urandom_range(0, 29) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      ds_valid     = ($urandom_range(0, 2) == 0);
      pipe1_valid  = $urandom_range(0, 1);
      r0.valid  = ($urandom_range(0, 2) == 0);
      r1.valid  = ($urandom_range(0, 2) == 0);
      r0.taken  = $urandom_range(0, 1);
      r1.taken  = $urandom_range(0, 1);
      r0.target = $urandom;
      r1.target = $urandom;
      pc0 = $urandom;
      pc1 = $urandom;
      pk0 = ($urandom_range(0, 2) == 0) ? ~r0.taken : r0.taken;
      pk1 = ($urandom_range(0, 2) == 0) ? ~r1.taken : r1.taken;
      pt0 = ($urandom_range(0, 3) == 0) ? r0.target + 32'd4 : r0.target;
      pt1 = ($urandom_range(0, 3) == 0) ? r1.target + 32'd4 : r1.target;
      if ($urandom_range(0, 15) == 0) pc0 = 32'hFFFF_FFFC;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
